// File: rtl/ddr3_rd_arbiter.sv
// Shares the DDR3 EMIF read port between two read masters; a tag FIFO routes returned beats to their owner.
// Build option: DDR3_ARB_FIXED_PRIO_EN gives req0 strict priority instead of round robin.
module ddr3_rd_arbiter #(
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 256,
    parameter int BURST_W   = 5,
    parameter int TAG_DEPTH = 8
) (
    input  logic               ddr_emif_clk,
    input  logic               ddr_emif_rst_n,
    input  logic               req0_read,
    input  logic [ADDR_W-1:0]  req0_addr,
    input  logic [BURST_W-1:0] req0_burst_count,
    output logic               req0_ready,
    output logic [DATA_W-1:0]  req0_rddata,
    output logic               req0_rddata_valid,
    input  logic               req1_read,
    input  logic [ADDR_W-1:0]  req1_addr,
    input  logic [BURST_W-1:0] req1_burst_count,
    output logic               req1_ready,
    output logic [DATA_W-1:0]  req1_rddata,
    output logic               req1_rddata_valid,
    input  logic               ddr_emif_ready,
    output logic               ddr_emif_read,
    output logic [ADDR_W-1:0]  ddr_emif_addr,
    output logic [BURST_W-1:0] ddr_emif_burst_count,
    input  logic [DATA_W-1:0]  ddr_emif_read_data,
    input  logic               ddr_emif_rddata_valid,
    output logic               arb_err_unexpected
);
    // state     | meaning
    // ARB_IDLE  | no command on EMIF; arbitrate when a request and a free tag exist
    // ARB_ISSUE | command held on EMIF until ddr_emif_ready accepts it
    localparam logic [0:0] ARB_IDLE  = 1'b0;
    localparam logic [0:0] ARB_ISSUE = 1'b1;
    localparam int PTR_W = $clog2(TAG_DEPTH);

    logic [0:0]         state;
    logic               grant_id;
    logic               winner;
    logic               any_req;
    logic               accept;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               head_id;
    logic               beat_ok;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic [BURST_W-1:0] beat_cnt;
    logic [BURST_W-1:0] head_len;
    logic               tag_id    [TAG_DEPTH];
    logic [BURST_W-1:0] tag_burst [TAG_DEPTH];

    assign any_req = req0_read | req1_read;

`ifdef DDR3_ARB_FIXED_PRIO_EN
    assign winner = ~req0_read;
`else
    logic rr_ptr;

    assign winner = (req0_read & req1_read) ? rr_ptr : req1_read;

    always_ff @(posedge ddr_emif_clk or negedge ddr_emif_rst_n) begin
        if (!ddr_emif_rst_n) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= ~grant_id;
        end
    end
`endif

    assign accept     = (state == ARB_ISSUE) & ddr_emif_read & ddr_emif_ready;
    assign req0_ready = accept & ~grant_id;
    assign req1_ready = accept & grant_id;

    assign fifo_full  = (count == (PTR_W+1)'(TAG_DEPTH));
    assign fifo_empty = (count == '0);
    assign head_id    = tag_id[rd_ptr];
    assign head_len   = (tag_burst[rd_ptr] == '0) ? BURST_W'(1) : tag_burst[rd_ptr];
    assign beat_ok    = ddr_emif_rddata_valid & ~fifo_empty;
    assign pop        = beat_ok & (beat_cnt == head_len - BURST_W'(1));

    assign req0_rddata       = ddr_emif_read_data;
    assign req1_rddata       = ddr_emif_read_data;
    assign req0_rddata_valid = beat_ok & ~head_id;
    assign req1_rddata_valid = beat_ok & head_id;

    always_ff @(posedge ddr_emif_clk or negedge ddr_emif_rst_n) begin
        if (!ddr_emif_rst_n) begin
            state                <= ARB_IDLE;
            grant_id             <= 1'b0;
            ddr_emif_read        <= 1'b0;
            ddr_emif_addr        <= '0;
            ddr_emif_burst_count <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_req && !fifo_full) begin
                        grant_id             <= winner;
                        ddr_emif_read        <= 1'b1;
                        ddr_emif_addr        <= winner ? req1_addr : req0_addr;
                        ddr_emif_burst_count <= winner ? req1_burst_count : req0_burst_count;
                        state                <= ARB_ISSUE;
                    end
                end
                default: begin
                    if (accept) begin
                        ddr_emif_read <= 1'b0;
                        state         <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge ddr_emif_clk) begin
        if (accept) begin
            tag_id[wr_ptr]    <= grant_id;
            tag_burst[wr_ptr] <= ddr_emif_burst_count;
        end
    end

    always_ff @(posedge ddr_emif_clk or negedge ddr_emif_rst_n) begin
        if (!ddr_emif_rst_n) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            beat_cnt           <= '0;
            arb_err_unexpected <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (accept && !pop) begin
                count <= count + (PTR_W+1)'(1);
            end else if (pop && !accept) begin
                count <= count - (PTR_W+1)'(1);
            end
            if (beat_ok) begin
                beat_cnt <= pop ? '0 : beat_cnt + BURST_W'(1);
            end
            if (ddr_emif_rddata_valid && fifo_empty) begin
                arb_err_unexpected <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_rd_arbiter.sv
// Directed self-checking bench for ddr3_rd_arbiter; expectations follow DDR3_ARB_FIXED_PRIO_EN when defined.
module tb_ddr3_rd_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_read, req1_read;
    logic [21:0]  req0_addr, req1_addr;
    logic [4:0]   req0_burst_count, req1_burst_count;
    logic         req0_ready, req1_ready;
    logic [255:0] req0_rddata, req1_rddata;
    logic         req0_rddata_valid, req1_rddata_valid;
    logic         ddr_emif_ready, ddr_emif_read;
    logic [21:0]  ddr_emif_addr;
    logic [4:0]   ddr_emif_burst_count;
    logic [255:0] ddr_emif_read_data;
    logic         ddr_emif_rddata_valid;
    logic         arb_err_unexpected;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ddr3_rd_arbiter dut (
        .ddr_emif_clk         (clk),
        .ddr_emif_rst_n       (rst_n),
        .req0_read            (req0_read),
        .req0_addr            (req0_addr),
        .req0_burst_count     (req0_burst_count),
        .req0_ready           (req0_ready),
        .req0_rddata          (req0_rddata),
        .req0_rddata_valid    (req0_rddata_valid),
        .req1_read            (req1_read),
        .req1_addr            (req1_addr),
        .req1_burst_count     (req1_burst_count),
        .req1_ready           (req1_ready),
        .req1_rddata          (req1_rddata),
        .req1_rddata_valid    (req1_rddata_valid),
        .ddr_emif_ready       (ddr_emif_ready),
        .ddr_emif_read        (ddr_emif_read),
        .ddr_emif_addr        (ddr_emif_addr),
        .ddr_emif_burst_count (ddr_emif_burst_count),
        .ddr_emif_read_data   (ddr_emif_read_data),
        .ddr_emif_rddata_valid(ddr_emif_rddata_valid),
        .arb_err_unexpected   (arb_err_unexpected)
    );

    task automatic issue(input bit id, input logic [21:0] a, input logic [4:0] b,
                         input int budget, output bit ok);
        ok = 1'b0;
        if (id) begin
            req1_read = 1'b1; req1_addr = a; req1_burst_count = b;
        end else begin
            req0_read = 1'b1; req0_addr = a; req0_burst_count = b;
        end
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            if (id ? req1_ready : req0_ready) ok = 1'b1;
        end
        if (id) req1_read = 1'b0; else req0_read = 1'b0;
    endtask

    task automatic beat(input logic [255:0] d);
        @(negedge clk);
        ddr_emif_rddata_valid = 1'b1;
        ddr_emif_read_data    = d;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_read = 0; req1_read = 0; req0_addr = 0; req1_addr = 0;
        req0_burst_count = 0; req1_burst_count = 0;
        ddr_emif_ready = 0; ddr_emif_read_data = '0; ddr_emif_rddata_valid = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({ddr_emif_read, req0_ready, req1_ready, req0_rddata_valid, req1_rddata_valid,
             arb_err_unexpected} !== 6'b0 || ddr_emif_addr !== 22'h0 || ddr_emif_burst_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: read=%b addr=%h burst=%0d rdy=%b%b vld=%b%b err=%b, expected all 0",
                     ddr_emif_read, ddr_emif_addr, ddr_emif_burst_count, req0_ready, req1_ready,
                     req0_rddata_valid, req1_rddata_valid, arb_err_unexpected);
        end
        req0_read = 1'b1; req0_addr = 22'h10; req0_burst_count = 5'd4;
        @(negedge clk);
        checks++;
        if (ddr_emif_read !== 1'b1 || ddr_emif_addr !== 22'h10 || ddr_emif_burst_count !== 5'd4) begin
            errors++;
            $display("FAIL first_cmd: read=%b addr=%h burst=%0d, expected 1 10 4",
                     ddr_emif_read, ddr_emif_addr, ddr_emif_burst_count);
        end
    endtask

    task automatic test_ready_stall();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ddr_emif_read !== 1'b1 || ddr_emif_addr !== 22'h10 || req0_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: read=%b addr=%h ready0=%b, expected 1 10 0",
                         i, ddr_emif_read, ddr_emif_addr, req0_ready);
            end
        end
        ddr_emif_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_pulse: ready0=%b ready1=%b, expected 1 0", req0_ready, req1_ready);
        end
        req0_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (req0_ready !== 1'b0 || ddr_emif_read !== 1'b0) begin
                errors++;
                $display("FAIL ready_once[%0d]: ready0=%b read=%b, expected 0 0", i, req0_ready, ddr_emif_read);
            end
        end
    endtask

    task automatic test_return_routing();
        bit ok;
        logic [255:0] d;
        issue(1'b1, 22'h20, 5'd2, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL issue_req1: no req1_ready within 20 cycles, expected grant");
        end
        for (int k = 0; k < 6; k++) begin
            d = {8{32'hA0 + 32'(k)}};
            beat(d);
            checks++;
            if (req0_rddata_valid !== (k < 4) || req1_rddata_valid !== (k >= 4) ||
                (k < 4 ? req0_rddata : req1_rddata) !== d) begin
                errors++;
                $display("FAIL return_beat[%0d]: vld0=%b vld1=%b data_ok=%b, expected vld0=%b vld1=%b",
                         k, req0_rddata_valid, req1_rddata_valid,
                         ((k < 4 ? req0_rddata : req1_rddata) === d), (k < 4), (k >= 4));
            end
        end
        @(negedge clk);
        ddr_emif_rddata_valid = 1'b0;
    endtask

    task automatic test_arbitration();
        bit           g [4];
        logic [21:0]  ga [4];
        bit           exp_id;
        int           n = 0;
        req0_addr = 22'h100; req1_addr = 22'h200;
        req0_burst_count = 5'd1; req1_burst_count = 5'd1;
        req0_read = 1'b1; req1_read = 1'b1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk); #1;
            if (req0_ready || req1_ready) begin
                g[n]  = req1_ready;
                ga[n] = ddr_emif_addr;
                n++;
            end
        end
        req0_read = 1'b0; req1_read = 1'b0;
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL arb_grants: got %0d grants, expected 4", n);
        end
        for (int i = 0; i < n; i++) begin
`ifdef DDR3_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = (i % 2) == 1;
`endif
            checks++;
            if (g[i] !== exp_id || ga[i] !== (exp_id ? 22'h200 : 22'h100)) begin
                errors++;
                $display("FAIL arb_order[%0d]: id=%0d addr=%h, expected id=%0d addr=%h",
                         i, g[i], ga[i], exp_id, exp_id ? 22'h200 : 22'h100);
            end
        end
        for (int i = 0; i < n; i++) begin
`ifdef DDR3_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = (i % 2) == 1;
`endif
            beat({8{32'hB0 + 32'(i)}});
            checks++;
            if (req0_rddata_valid !== !exp_id || req1_rddata_valid !== exp_id) begin
                errors++;
                $display("FAIL arb_return[%0d]: vld0=%b vld1=%b, expected vld1=%0d",
                         i, req0_rddata_valid, req1_rddata_valid, exp_id);
            end
        end
        @(negedge clk);
        ddr_emif_rddata_valid = 1'b0;
    endtask

    task automatic test_fifo_full();
        bit ok;
        bit leaked = 1'b0;
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 22'h300 + 22'(i), 5'd1, 10, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL fill_issue[%0d]: no req0_ready within 10 cycles, expected grant", i);
            end
        end
        req0_read = 1'b1; req0_addr = 22'h3FF; req0_burst_count = 5'd1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (ddr_emif_read !== 1'b0 || req0_ready !== 1'b0) leaked = 1'b1;
        end
        checks++;
        if (leaked) begin
            errors++;
            $display("FAIL full_block: command issued with 8 outstanding, expected no command");
        end
        beat({8{32'hC0}});
        checks++;
        if (req0_rddata_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_first_return: vld0=%b, expected 1", req0_rddata_valid);
        end
        @(negedge clk);
        ddr_emif_rddata_valid = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            #1;
            if (req0_ready) ok = 1'b1;
            @(negedge clk);
        end
        req0_read = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL full_resume: 9th request not granted within 10 cycles, expected grant");
        end
        for (int i = 0; i < 8; i++) begin
            beat({8{32'hD0 + 32'(i)}});
            checks++;
            if (req0_rddata_valid !== 1'b1 || req1_rddata_valid !== 1'b0) begin
                errors++;
                $display("FAIL full_drain[%0d]: vld0=%b vld1=%b, expected 1 0",
                         i, req0_rddata_valid, req1_rddata_valid);
            end
        end
        @(negedge clk);
        ddr_emif_rddata_valid = 1'b0;
        checks++;
        if (arb_err_unexpected !== 1'b0) begin
            errors++;
            $display("FAIL no_spurious_err: err=%b, expected 0", arb_err_unexpected);
        end
    endtask

    task automatic test_unexpected();
        beat({8{32'hEE}});
        checks++;
        if (req0_rddata_valid !== 1'b0 || req1_rddata_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_routed: vld0=%b vld1=%b, expected 0 0", req0_rddata_valid, req1_rddata_valid);
        end
        @(negedge clk);
        ddr_emif_rddata_valid = 1'b0;
        checks++;
        if (arb_err_unexpected !== 1'b1) begin
            errors++;
            $display("FAIL err_set: err=%b, expected 1", arb_err_unexpected);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (arb_err_unexpected !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b, expected 1", arb_err_unexpected);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (arb_err_unexpected !== 1'b0) begin
            errors++;
            $display("FAIL err_reset_clear: err=%b, expected 0", arb_err_unexpected);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        issue(1'b1, 22'h40, 5'd4, 10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_issue: no req1_ready within 10 cycles, expected grant");
        end
        beat({8{32'hF0}});
        beat({8{32'hF1}});
        @(negedge clk);
        ddr_emif_rddata_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        beat({8{32'hF2}});
        checks++;
        if (req0_rddata_valid !== 1'b0 || req1_rddata_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_stray_routed: vld0=%b vld1=%b, expected 0 0", req0_rddata_valid, req1_rddata_valid);
        end
        @(negedge clk);
        ddr_emif_rddata_valid = 1'b0;
        checks++;
        if (arb_err_unexpected !== 1'b1) begin
            errors++;
            $display("FAIL mid_stray_err: err=%b, expected 1", arb_err_unexpected);
        end
    endtask

    initial begin
        test_reset();
        test_ready_stall();
        test_return_routing();
        test_arbitration();
        test_fifo_full();
        test_unexpected();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units, expected completion");
        $fatal(1);
    end
endmodule
